// File: rtl/sw_led_pkg.sv
// rtl/sw_led_pkg.sv - shared mode encodings and counter sizing for the switch/LED bank
package sw_led_pkg;

    localparam logic [1:0] MODE_DIRECT = 2'b00;
    localparam logic [1:0] MODE_TOGGLE = 2'b01;
    localparam logic [1:0] MODE_BLINK  = 2'b10;
    localparam logic [1:0] MODE_OFF    = 2'b11;

    // Width of a counter that must hold values 0..n.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/sw_debounce.sv
// rtl/sw_debounce.sv - one channel: 2-flop synchroniser, debounce counter, stable level, change pulse
module sw_debounce
    import sw_led_pkg::*;
#(
    parameter int DB_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sw_i,      // raw switch pin, asynchronous
    output logic stable_o,  // debounced level
    output logic rise_o,    // combinational: stable is about to rise on this edge
    output logic evt_o      // registered one-cycle pulse, one cycle after stable changes
);

    localparam int             CW       = cnt_width(DB_CYCLES);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DB_CYCLES - 1);

    logic          s1_q, s1_d;
    logic          s2_q, s2_d;
    logic          stable_q, stable_d;
    logic          stable_dly_q, stable_dly_d;
    logic          evt_q, evt_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          accept;

    always_comb begin
        s1_d         = sw_i;
        s2_d         = s1_q;
        stable_d     = stable_q;
        cnt_d        = cnt_q;
        accept       = 1'b0;
        if (s2_q == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            accept   = 1'b1;
            stable_d = s2_q;
            cnt_d    = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
        // The event is taken from the already-updated stable level, so it
        // trails the stable change by exactly one cycle.
        stable_dly_d = stable_q;
        evt_d        = stable_q ^ stable_dly_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q         <= 1'b0;
            s2_q         <= 1'b0;
            stable_q     <= 1'b0;
            stable_dly_q <= 1'b0;
            evt_q        <= 1'b0;
            cnt_q        <= '0;
        end else begin
            s1_q         <= s1_d;
            s2_q         <= s2_d;
            stable_q     <= stable_d;
            stable_dly_q <= stable_dly_d;
            evt_q        <= evt_d;
            cnt_q        <= cnt_d;
        end
    end

    assign stable_o = stable_q;
    assign rise_o   = accept & s2_q;
    assign evt_o    = evt_q;

endmodule

// File: rtl/sw_led_bank.sv
// rtl/sw_led_bank.sv - N_CH switch-to-LED bank (direct/toggle/blink/off); blink built only with SW_LED_BLINK_EN
module sw_led_bank
    import sw_led_pkg::*;
#(
    parameter int N_CH         = 8,
    parameter int DB_CYCLES    = 1_000_000,
    parameter int BLINK_CYCLES = 25_000_000
) (
    input  logic            clk,
    input  logic            rst_n,   // asynchronous, active-low
    input  logic [N_CH-1:0] sw,      // raw switch pins
    input  logic [1:0]      mode,    // shared output mode
    output logic [N_CH-1:0] led,     // registered LED drive
    output logic [N_CH-1:0] sw_db,   // debounced levels
    output logic [N_CH-1:0] sw_evt   // one-cycle change pulses
);

    logic [N_CH-1:0] rise;
    logic [N_CH-1:0] tgl_q, tgl_d;
    logic [N_CH-1:0] led_q, led_d;
    logic [N_CH-1:0] blink_val;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        sw_debounce #(
            .DB_CYCLES(DB_CYCLES)
        ) u_db (
            .clk      (clk),
            .rst_n    (rst_n),
            .sw_i     (sw[i]),
            .stable_o (sw_db[i]),
            .rise_o   (rise[i]),
            .evt_o    (sw_evt[i])
        );
    end

`ifdef SW_LED_BLINK_EN
    localparam int            BW      = cnt_width(BLINK_CYCLES);
    localparam logic [BW-1:0] BL_LAST = BW'(BLINK_CYCLES - 1);

    logic [BW-1:0] bl_cnt_q, bl_cnt_d;
    logic          ph_q, ph_d;
    logic          wrap;

    always_comb begin
        wrap      = (bl_cnt_q == BL_LAST);
        bl_cnt_d  = wrap ? '0 : bl_cnt_q + BW'(1);
        ph_d      = ph_q ^ wrap;
        blink_val = sw_db & {N_CH{ph_q}};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bl_cnt_q <= '0;
            ph_q     <= 1'b0;
        end else begin
            bl_cnt_q <= bl_cnt_d;
            ph_q     <= ph_d;
        end
    end
`else
    // Without the blink hardware, blink mode degenerates to direct.
    always_comb begin
        blink_val = sw_db;
    end
`endif

    always_comb begin
        // Toggle state tracks debounced rises regardless of the active mode.
        tgl_d = tgl_q ^ rise;
        led_d = '0;
        case (mode)
            MODE_DIRECT: led_d = sw_db;
            MODE_TOGGLE: led_d = tgl_q;
            MODE_BLINK:  led_d = blink_val;
            default:     led_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tgl_q <= '0;
            led_q <= '0;
        end else begin
            tgl_q <= tgl_d;
            led_q <= led_d;
        end
    end

    assign led = led_q;

endmodule
